// File: rtl/alu_seq.sv
// Multi-cycle ALU: operands are processed CHUNK bits per clock through a ripple-carry slice.
// Optional feature macro ALU_SEQ_ACCUM_EN: acc_sel=1 at accept takes operand A from the result register.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             acc_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int LW    = $clog2(WIDTH);
    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_NAND = 4'd2, OP_NOR = 4'd3,
                           OP_XOR = 4'd4, OP_XNOR = 4'd5, OP_NOT = 4'd6, OP_ADD = 4'd7,
                           OP_SUB = 4'd8, OP_DEC = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, shadow_q, shadow_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [CHUNK-1:0]   a_ch, b_ch, r_ch;
    logic [CHUNK:0]     sum_ch;
    logic [WIDTH-1:0]   dec_w, shadow_nx, a_src;
    logic               is_arith;

`ifdef ALU_SEQ_ACCUM_EN
    assign a_src = acc_sel ? result_q : a;
`else
    logic unused_acc_sel;
    assign unused_acc_sel = acc_sel;
    assign a_src          = a;
`endif

    // One chunk slice: logic ops and ripple-carry add on the current CHUNK bits
    always_comb begin
        a_ch     = a_q[idx_q*CHUNK +: CHUNK];
        b_ch     = b_q[idx_q*CHUNK +: CHUNK];
        sum_ch   = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        dec_w    = {{(WIDTH-1){1'b0}}, 1'b1} << a_q[LW-1:0];
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        case (op_q)
            OP_AND:  r_ch = a_ch & b_ch;
            OP_OR:   r_ch = a_ch | b_ch;
            OP_NAND: r_ch = ~(a_ch & b_ch);
            OP_NOR:  r_ch = ~(a_ch | b_ch);
            OP_XOR:  r_ch = a_ch ^ b_ch;
            OP_XNOR: r_ch = ~(a_ch ^ b_ch);
            OP_NOT:  r_ch = ~a_ch;
            OP_ADD, OP_SUB: r_ch = sum_ch[CHUNK-1:0];
            OP_DEC:  r_ch = dec_w[idx_q*CHUNK +: CHUNK];
            default: r_ch = '0;
        endcase
        shadow_nx = shadow_q;
        shadow_nx[idx_q*CHUNK +: CHUNK] = r_ch;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        shadow_d = shadow_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_EXEC: begin
                shadow_d = shadow_nx;
                carry_d  = sum_ch[CHUNK];
                idx_d    = idx_q + 1'b1;
                if (idx_q == IDX_W'(N-1)) begin
                    result_d = shadow_nx;
                    cout_d   = is_arith & sum_ch[CHUNK];
                    ovf_d    = is_arith && (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (shadow_nx[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d   = (shadow_nx == '0);
                    state_d  = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise
                if (start) begin
                    state_d = S_EXEC;
                    op_d    = op;
                    a_d     = a_src;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    carry_d = (op == OP_ADD) ? cin : (op == OP_SUB);
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Operand and partial-result datapath carries no reset
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        a_q      <= a_d;
        b_q      <= b_d;
        carry_q  <= carry_d;
        shadow_q <= shadow_d;
    end

    assign busy     = (state_q == S_EXEC);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=16, CHUNK=4) against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 16;
    localparam int N = 4;
`ifdef ALU_SEQ_ACCUM_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start, cin, acc_sel;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, cout, overflow, zero;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    alu_seq #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cin(cin), .acc_sel(acc_sel), .busy(busy), .done(done),
        .result(result), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0] s;
        r = '0; c = 1'b0; v = 1'b0;
        case (o)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd2: r = ~(x & y);
            4'd3: r = ~(x | y);
            4'd4: r = x ^ y;
            4'd5: r = ~(x ^ y);
            4'd6: r = ~x;
            4'd7: begin
                s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'd8: begin
                r = x - y;
                c = (x >= y);
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'd9: r = 16'd1 << x[3:0];
            default: r = '0;
        endcase
    endfunction

    // Reference: an accepted op completes N edges later; requests while pending are dropped
    int           rem = 0;
    bit           armed = 1'b0;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_cout = 1'b0, m_ov = 1'b0, m_zero = 1'b1, m_done = 1'b0;
    logic         p_cout = 1'b0, p_ov = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0] opa;
        if (!rst_n) begin
            rem = 0; m_res = '0; m_cout = 1'b0; m_ov = 1'b0; m_zero = 1'b1; m_done = 1'b0;
            armed = 1'b1;
        end else begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_res = p_res; m_cout = p_cout; m_ov = p_ov; m_zero = (p_res == '0);
                    m_done = 1'b1;
                end
            end else if (start) begin
                opa = (ACC_EN && acc_sel) ? m_res : a;
                ref_op(op, opa, b, cin, p_res, p_cout, p_ov);
                rem = N;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(busy), 32'(rem > 0));
            chk("done", 32'(done), 32'(m_done));
            chk("result", 32'(result), 32'(m_res));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("overflow", 32'(overflow), 32'(m_ov));
            chk("zero", 32'(zero), 32'(m_zero));
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout actual=no_done expected=done at %0t", $time);
        end
    endtask

    // Issues one op from a negedge; returns at the negedge where done is seen
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic as, output int lat);
        op = o; a = x; b = y; cin = ci; acc_sel = as; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        lat = lat + 0;
    endtask

    task automatic lit(input string nm, input logic [W-1:0] r, input logic c, input logic v, input logic z);
        chk({nm, "_res"}, 32'(result), 32'(r));
        chk({nm, "_cout"}, 32'(cout), 32'(c));
        chk({nm, "_ovf"}, 32'(overflow), 32'(v));
        chk({nm, "_zero"}, 32'(zero), 32'(z));
    endtask

    initial begin
        int lat, dc0;
        logic [W-1:0] e1, e2, e3;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0; acc_sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        lit("rst", 16'h0000, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(4'd7, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("add_lat", 32'(lat), 32'd4);
        lit("add", 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op(4'd8, 16'h8000, 16'h0001, 1'b0, 1'b0, lat);
        lit("sub1", 16'h7FFF, 1'b1, 1'b1, 1'b0);
        do_op(4'd8, 16'h0001, 16'h0002, 1'b1, 1'b0, lat);
        lit("sub2", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        do_op(4'd5, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, lat);
        lit("xnor", 16'hF00F, 1'b0, 1'b0, 1'b0);
        do_op(4'd9, 16'h000F, 16'h0000, 1'b0, 1'b0, lat);
        lit("dec", 16'h8000, 1'b0, 1'b0, 1'b0);
        do_op(4'd6, 16'h1234, 16'hFFFF, 1'b0, 1'b0, lat);
        lit("not", 16'hEDCB, 1'b0, 1'b0, 1'b0);
        do_op(4'd12, 16'h1234, 16'h5678, 1'b1, 1'b0, lat);
        chk("ill_lat", 32'(lat), 32'd4);
        lit("ill", 16'h0000, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Start while busy is ignored; start in the done cycle is accepted
        dc0 = done_cnt;
        op = 4'd7; a = 16'h1111; b = 16'h2222; cin = 1'b0; acc_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        op = 4'd8; a = 16'hFFFF; b = 16'h0F0F;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        lit("ovl", 16'h3333, 1'b0, 1'b0, 1'b0);
        do_op(4'd4, 16'hAAAA, 16'h5555, 1'b0, 1'b0, lat);
        chk("b2b_lat", 32'(lat), 32'd4);
        lit("b2b", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("ovl_done_cnt", 32'(done_cnt - dc0), 32'd2);

        // Reset in the 2nd EXEC cycle aborts without a done pulse
        dc0 = done_cnt;
        op = 4'd7; a = 16'h7000; b = 16'h1000; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        lit("abort", 16'h0000, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        chk("abort_done_cnt", 32'(done_cnt - dc0), 32'd0);
        do_op(4'd7, 16'h0005, 16'h0006, 1'b0, 1'b0, lat);
        chk("post_lat", 32'(lat), 32'd4);
        lit("post", 16'h000B, 1'b0, 1'b0, 1'b0);

        // Accumulate: three ADDs of 3 starting from a freshly reset result
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e1 = 16'h0003;
        e2 = ACC_EN ? 16'h0006 : 16'h0003;
        e3 = ACC_EN ? 16'h0009 : 16'h0003;
        do_op(4'd7, 16'h0000, 16'h0003, 1'b0, 1'b1, lat);
        chk("acc1", 32'(result), 32'(e1));
        do_op(4'd7, 16'h0000, 16'h0003, 1'b0, 1'b1, lat);
        chk("acc2", 32'(result), 32'(e2));
        do_op(4'd7, 16'h0000, 16'h0003, 1'b0, 1'b1, lat);
        chk("acc3", 32'(result), 32'(e3));

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 2) != 0);
            op      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            case ($urandom_range(0, 5))
                0: a = 16'hFFFF;
                1: a = 16'h8000;
                2: a = 16'h0000;
                default: a = 16'($urandom);
            endcase
            b       = ($urandom_range(0, 4) == 0) ? 16'h0001 : 16'($urandom);
            cin     = 1'($urandom);
            acc_sel = 1'($urandom);
            rst_n   = ($urandom_range(0, 99) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU that extends the team's combinational gate, adder, subtractor and decoder primitives into one registered, handshaked unit. Operands are processed CHUNK bits per clock through a ripple-carry slice, which keeps the critical path short at large WIDTH. The block sits between a register file or testbench driver and the result bus. Results, carry, overflow and zero flags are registered and announced with a one-cycle done pulse.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK and a power of two ≥ 4
- CHUNK, 4, bits processed per EXEC cycle; N = WIDTH/CHUNK

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; accepted only when busy=0
- op  in  4  opcode, sampled at accept
- a  in  WIDTH  operand A, sampled at accept
- b  in  WIDTH  operand B, sampled at accept
- cin  in  1  carry-in for ADD, sampled at accept
- acc_sel  in  1  use previous result as A (see Configuration)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result/flags just updated
- result  out  WIDTH  registered result
- cout  out  1  carry-out (ADD) / no-borrow (SUB); 0 otherwise
- overflow  out  1  signed overflow (ADD/SUB); 0 otherwise
- zero  out  1  result == 0

## Operation
- Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 ADD (A+B+cin), 8 SUB (A+~B+1, cin ignored), 9 DECODE (result = 1 << A[log2(WIDTH)-1:0]), 10–15 illegal.
- Illegal op: runs the full N cycles; result=0, cout=0, overflow=0, zero=1.
- FSM: IDLE → (start) EXEC → after chunk N-1 → DONE → IDLE, or DONE → EXEC if start is high in DONE.
- At accept: latch op, A, B (inverted for SUB), first-chunk carry (cin for ADD, 1 for SUB, 0 otherwise); clear chunk index.
- EXEC: each cycle compute chunk k = [k*CHUNK +: CHUNK] into a shadow register; carry is held in a 1-bit register between chunks.
- Final chunk: copy shadow to result; set cout = final carry; overflow = (A[MSB]==B'[MSB]) && (res[MSB]!=A[MSB]), where B' is post-inversion B; zero from the full result.
- result and flags hold their values until the next completion. The partial result is never visible on result.

## Timing
- Reset: busy=0, done=0, result=0, cout=0, overflow=0, zero=1, FSM=IDLE, accumulator=0.
- Accept edge E0 (start=1, busy=0). busy=1 from E0 through E_N. Chunks are processed at edges E1..E_N.
- After E_N: result/flags valid, done=1, busy=0 for exactly one cycle.
- Latency is N cycles from accept to done. Start held continuously gives one op per N+1 cycles.
- start while busy=1: ignored. It is not queued, and there is no effect on operands.
- rst_n low at any edge mid-operation: abort, return to reset values, no done pulse.
- start and rst_n low together: reset wins.

## Configuration
- ALU_SEQ_ACCUM_EN defined: if acc_sel=1 at accept, operand A := current result register (the a port is ignored). The accumulator is cleared by reset only.
- ALU_SEQ_ACCUM_EN undefined: the acc_sel port exists but is ignored, and A is always the a port.

## Test plan
WIDTH=16, CHUNK=4, N=4:
- ADD a=0xFFFF b=0x0001 cin=0 → done exactly 4 cycles after accept; result=0x0000, cout=1, zero=1, overflow=0.
- SUB a=0x8000 b=0x0001 → result=0x7FFF, cout=1, overflow=1, zero=0. SUB a=0x0001 b=0x0002 → 0xFFFF, cout=0.
- XNOR a=0x00FF b=0x0F0F → 0xF00F. DECODE a=0x000F → 0x8000. NOT a=0x1234 → 0xEDCB. op=12 → result 0, zero=1.
- Start ADD, re-assert start with new operands during busy → first result is unaffected, only one done. Then reassert start in the done cycle → second op accepted, done 4 cycles later.
- Start ADD, pull rst_n low at the 2nd EXEC cycle → no done, all outputs at reset values, next op completes normally.
- With ALU_SEQ_ACCUM_EN, after reset: three ADDs with acc_sel=1 b=0x0003 cin=0 → results 0x0003, 0x0006, 0x0009. Without the macro, the same stimulus with a=0x0000 → 0x0003 each time.
